// File: rtl/prefix_addsub_pkg.sv
// Shared types and helpers for the Kogge-Stone adder/subtractor pipeline.
package prefix_addsub_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/prefix_addsub_pipe_gp_combine.sv
// Group generate/propagate combine cell used as the prefix tree node.
module gp_combine
  import prefix_addsub_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi | (p_hi & g_lo);
  assign p_o = p_hi & p_lo;

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Three-stage pipelined WIDTH-bit adder/subtractor with a Kogge-Stone carry tree
// and valid/ready handshakes on both sides.
module prefix_addsub_pipe
  import prefix_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LEVELS = clog2(WIDTH) + 1;
  localparam int unsigned NODES  = WIDTH + 1;

  logic             load1_c, load2_c, load3_c;
  logic [WIDTH-1:0] b_x;

  logic             s1_v_q, s1_v_d, s1_sub_q, s1_sub_d;
  gp_t [WIDTH-1:0]  s1_gp_q, s1_gp_d;
  logic             s2_v_q, s2_v_d, s2_sub_q, s2_sub_d;
  logic [WIDTH:0]   s2_c_q, s2_c_d;
  logic [WIDTH-1:0] s2_p_q, s2_p_d;
  logic             s3_v_q, s3_v_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, borrow_q, borrow_d;
  logic             ovf_q, ovf_d, zero_q, zero_d;

  // Prefix tree: node 0 is the carry-in (G=sub, P=0), node i+1 is bit i.
  logic [LEVELS:0][WIDTH:0] tg, tp;
  logic                     tree_p_unused;

  assign b_x = b ^ {WIDTH{sub}};

  assign tg[0][0] = s1_sub_q;
  assign tp[0][0] = 1'b0;
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_leaf
    assign tg[0][i+1] = s1_gp_q[i].g;
    assign tp[0][i+1] = s1_gp_q[i].p;
  end

  for (genvar l = 0; l < int'(LEVELS); l++) begin : g_lvl
    for (genvar j = 0; j < int'(NODES); j++) begin : g_node
      if (j >= (2 ** l)) begin : g_comb
        gp_combine u_node (
          .g_hi (tg[l][j]),
          .p_hi (tp[l][j]),
          .g_lo (tg[l][j-(2**l)]),
          .p_lo (tp[l][j-(2**l)]),
          .g_o  (tg[l+1][j]),
          .p_o  (tp[l+1][j])
        );
      end else begin : g_pass
        assign tg[l+1][j] = tg[l][j];
        assign tp[l+1][j] = tp[l][j];
      end
    end
  end

  // Full-span propagate always includes P[-1]=0, so it carries no information.
  assign tree_p_unused = ^tp[LEVELS];

  always_comb begin
    load3_c   = !s3_v_q || out_ready;
    load2_c   = !s2_v_q || load3_c;
    load1_c   = !s1_v_q || load2_c;

    s1_v_d    = s1_v_q;
    s1_sub_d  = s1_sub_q;
    s1_gp_d   = s1_gp_q;
    s2_v_d    = s2_v_q;
    s2_sub_d  = s2_sub_q;
    s2_c_d    = s2_c_q;
    s2_p_d    = s2_p_q;
    s3_v_d    = s3_v_q;
    result_d  = result_q;
    cout_d    = cout_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;

    if (load1_c) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sub_d = sub;
        for (int i = 0; i < int'(WIDTH); i++) begin
          s1_gp_d[i].g = a[i] & b_x[i];
          s1_gp_d[i].p = a[i] ^ b_x[i];
        end
      end
    end

    if (load2_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sub_d = s1_sub_q;
        s2_c_d   = tg[LEVELS];
        for (int i = 0; i < int'(WIDTH); i++) s2_p_d[i] = s1_gp_q[i].p;
      end
    end

    if (load3_c) begin
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        result_d = s2_p_q ^ s2_c_q[WIDTH-1:0];
        cout_d   = s2_c_q[WIDTH];
        borrow_d = s2_sub_q & ~s2_c_q[WIDTH];
        ovf_d    = s2_c_q[WIDTH] ^ s2_c_q[WIDTH-1];
        zero_d   = (result_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s3_v_q   <= s3_v_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Internal stage data is qualified by the valid bits and needs no reset.
  always_ff @(posedge clk) begin
    s1_sub_q <= s1_sub_d;
    s1_gp_q  <= s1_gp_d;
    s2_sub_q <= s2_sub_d;
    s2_c_q   <= s2_c_d;
    s2_p_q   <= s2_p_d;
  end

  assign in_ready  = load1_c;
  assign out_valid = s3_v_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench for prefix_addsub_pipe: directed corners, backpressure,
// mid-flight reset and a randomized stream against an arithmetic model.
module tb_prefix_addsub_pipe;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic         cout, borrow, ovf, zero;

  int n_vec = 0;
  int n_err = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  prefix_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .borrow(borrow), .ovf(ovf), .zero(zero)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t   e;
    longint ua, ub, sa, sb, full, sfull, smax, smin;
    ua = longint'(x);
    ub = longint'(y);
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (s) begin
      full   = ua - ub;
      sfull  = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      full   = ua + ub;
      sfull  = sa + sb;
      e.cout = (full >= (longint'(1) <<< W));
    end
    e.res    = W'(full);
    e.borrow = s & ~e.cout;
    e.ovf    = (sfull > smax) || (sfull < smin);
    e.zero   = (e.res == '0);
    return e;
  endfunction

  // One clock: drive inputs, sample at the falling edge, advance past the rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic is, input logic ord,
                       output logic in_fire, output logic out_fire,
                       output logic ovld, output exp_t obs);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = is;
    out_ready = ord;
    #4;
    in_fire  = iv && in_ready;
    ovld     = out_valid;
    out_fire = out_valid && ord;
    obs      = {result, cout, borrow, ovf, zero};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++;
    if ({result, cout, borrow, ovf, zero} !== '0)
      begin n_err++; $display("FAIL reset_outputs got %h want 0", {result, cout, borrow, ovf, zero}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000, 16'h0005};
    logic [W-1:0] tb [5] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0005};
    logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t         te [5] = '{{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1},
                             {16'h8000, 1'b0, 1'b0, 1'b1, 1'b0},
                             {16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0},
                             {16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0},
                             {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    logic inf, outf, ov;
    exp_t o;
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1, ta[t], tb[t], ts[t], 1'b1, inf, outf, ov, o);
      n_vec++;
      if (inf !== 1'b1) begin n_err++; $display("FAIL dir%0d_accept got %b want 1", t, inf); end
      for (int k = 1; k <= 3; k++) begin
        cycle(1'b0, '0, '0, 1'b0, 1'b1, inf, outf, ov, o);
        n_vec++;
        if (ov !== (k == 3)) begin
          n_err++; $display("FAIL dir%0d_latency cycle %0d out_valid got %b want %b", t, k, ov, (k == 3));
        end
        if (k == 3) begin
          n_vec++;
          if (o !== te[t]) begin n_err++; $display("FAIL dir%0d_value got %h want %h", t, o, te[t]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] oa [5], ob [5];
    logic         os [5];
    logic inf, outf, ov;
    exp_t o, e;
    int nx, got;
    for (int i = 0; i < 5; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); os[i] = 1'($urandom);
    end
    nx = 0; got = 0; expq.delete();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, oa[nx], ob[nx], os[nx], 1'b0, inf, outf, ov, o);
      n_vec++;
      if (inf !== (k < 3)) begin n_err++; $display("FAIL bp_in_ready cycle %0d got %b want %b", k, inf, (k < 3)); end
      if (inf) begin expq.push_back(model(oa[nx], ob[nx], os[nx])); nx++; end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, oa[nx], ob[nx], os[nx], 1'b0, inf, outf, ov, o);
      n_vec++;
      if (inf !== 1'b0 || ov !== 1'b1) begin
        n_err++; $display("FAIL bp_full got in_fire %b out_valid %b want 0 1", inf, ov);
      end
      n_vec++;
      if (expq.size() == 0 || o !== expq[0]) begin
        n_err++; $display("FAIL bp_hold got %h want %h", o, (expq.size() != 0) ? expq[0] : '0);
      end
    end
    for (int k = 0; k < 30 && got < 5; k++) begin
      cycle(nx < 5, oa[nx % 5], ob[nx % 5], os[nx % 5], 1'b1, inf, outf, ov, o);
      if (inf) begin expq.push_back(model(oa[nx], ob[nx], os[nx])); nx++; end
      if (outf) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL bp_extra got %h want none", o);
        end else begin
          e = expq.pop_front();
          if (o !== e) begin n_err++; $display("FAIL bp_order result %0d got %h want %h", got, o, e); end
        end
        got++;
      end
    end
    n_vec++;
    if (got !== 5) begin n_err++; $display("FAIL bp_drain got %0d results want 5", got); end
    cycle(1'b0, '0, '0, 1'b0, 1'b1, inf, outf, ov, o);
    n_vec++;
    if (ov !== 1'b0) begin n_err++; $display("FAIL bp_dup out_valid got %b want 0", ov); end
  endtask

  task automatic test_reset_midflight();
    logic inf, outf, ov;
    exp_t o;
    cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, inf, outf, ov, o);
    cycle(1'b1, 16'h4321, 16'h0001, 1'b1, 1'b0, inf, outf, ov, o);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_state got out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, inf, outf, ov, o);
      n_vec++;
      if (ov !== 1'b0) begin n_err++; $display("FAIL midrst_stale cycle %0d out_valid got %b want 0", k, ov); end
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    localparam int N = 10000;
    logic inf, outf, ov, iv, ord, s, prev_stall;
    logic [W-1:0] ra, rb;
    exp_t o, e, prev_o;
    int sent, got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_o = '0; expq.delete();
    for (int k = 0; k < 60000 && got < N; k++) begin
      iv  = (sent < N) && ($urandom_range(0, 9) < 7);
      ra  = pick_operand();
      rb  = pick_operand();
      s   = 1'($urandom);
      ord = ($urandom_range(0, 9) < 7);
      cycle(iv, ra, rb, s, ord, inf, outf, ov, o);
      if (prev_stall) begin
        n_vec++;
        if (ov !== 1'b1 || o !== prev_o) begin
          n_err++; $display("FAIL rnd_stall got valid %b %h want 1 %h", ov, o, prev_o);
        end
      end
      if (inf) begin expq.push_back(model(ra, rb, s)); sent++; end
      if (outf) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL rnd_extra got %h want none", o);
        end else begin
          e = expq.pop_front();
          if (o !== e) begin n_err++; $display("FAIL rnd_value #%0d got %h want %h", got, o, e); end
        end
        got++;
      end
      prev_stall = ov && !ord;
      prev_o     = o;
    end
    n_vec++;
    if (got !== N) begin n_err++; $display("FAIL rnd_count got %0d results want %0d", got, N); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
